dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the pipeline memory-access stage (requester P) and an external requester X (program loader / debug port).
- Sits between the memory stage's `we`/`data_addr`/`din`/`dout` lines and the data memory.
- Issues at most one access per cycle and routes read data back with a tagged latency pipe.
- Stalls the pipeline when P loses arbitration; starvation of X is bounded by a wait counter.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between the requesters, the data memory and the arbiter
//
// Signals:
//   p_req/p_we/p_addr/p_wdata      pipeline memory-stage request
//   p_stall/p_rdata/p_rvalid       pipeline stall and read return
//   x_req/x_we/x_addr/x_wdata      external (loader/debug) request
//   x_gnt/x_rdata/x_rvalid         external grant and read return
//   mem_we/mem_addr/mem_din        data memory command
//   mem_dout                       data memory read data
// Modports:
//   slave   arbiter view (serves both requesters, drives the memory)
//   master  environment view (requesters and memory)
interface dmem_arbiter_if;
    logic        p_req;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_stall;
    logic [31:0] p_rdata;
    logic        p_rvalid;

    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_gnt;
    logic [31:0] x_rdata;
    logic        x_rvalid;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_stall, p_rdata, p_rvalid,
        input  x_req, x_we, x_addr, x_wdata,
        output x_gnt, x_rdata, x_rvalid,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_stall, p_rdata, p_rvalid,
        output x_req, x_we, x_addr, x_wdata,
        input  x_gnt, x_rdata, x_rvalid,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between pipeline (P) and external (X) requesters
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   dmem_arbiter_if.slave: P and X request/return channels and the memory command port
// Parameters:
//   READ_LATENCY  cycles from memory address to valid mem_dout (1..4)
//   MAX_WAIT      consecutive denied cycles after which X is forced a grant (1..255)
module dmem_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_WAIT     = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // Arbitration
    logic x_forced;
    logic p_gnt;
    logic x_gnt;
    logic p_stall;

    // Memory command
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;

    // Registered copies so an idle cycle replays the last address/data instead of X
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q,  din_d;

    // Consecutive-denial counter for X
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Read return pipe; owner bit 1 means the read belongs to X
    logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [READ_LATENCY-1:0] pipe_owner_q, pipe_owner_d;
    logic                    push_valid;
    logic                    push_owner;

    // Every output is forced quiet while reset is asserted, whatever the requests say.
    always_comb begin
        x_forced = bus.x_req & (wait_cnt_q == MAX_WAIT_C);
        p_gnt    = ~rst & bus.p_req & ~x_forced;
        x_gnt    = ~rst & bus.x_req & ~p_gnt;
        p_stall  = ~rst & bus.p_req & ~p_gnt;
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (rst) begin
            mem_addr = 32'd0;
            mem_din  = 32'd0;
        end else if (p_gnt) begin
            mem_we   = bus.p_we;
            mem_addr = bus.p_addr;
            mem_din  = bus.p_wdata;
        end else if (x_gnt) begin
            mem_we   = bus.x_we;
            mem_addr = bus.x_addr;
            mem_din  = bus.x_wdata;
        end
        addr_d = mem_addr;
        din_d  = mem_din;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (x_gnt | ~bus.x_req) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // A request only enters the pipe in its grant cycle, so a held (stalled)
    // P request is never issued twice.
    always_comb begin
        push_valid = (p_gnt | x_gnt) & ~mem_we;
        push_owner = x_gnt;
        pipe_valid_d    = pipe_valid_q;
        pipe_owner_d    = pipe_owner_q;
        pipe_valid_d[0] = push_valid;
        pipe_owner_d[0] = push_owner;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_owner_d[i] = pipe_owner_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= 32'd0;
            din_q        <= 32'd0;
            wait_cnt_q   <= 8'd0;
            pipe_valid_q <= '0;
            pipe_owner_q <= '0;
        end else begin
            addr_q       <= addr_d;
            din_q        <= din_d;
            wait_cnt_q   <= wait_cnt_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_owner_q <= pipe_owner_d;
        end
    end

    assign bus.p_stall  = p_stall;
    assign bus.x_gnt    = x_gnt;
    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;

    assign bus.p_rvalid = ~rst & pipe_valid_q[READ_LATENCY-1] & ~pipe_owner_q[READ_LATENCY-1];
    assign bus.x_rvalid = ~rst & pipe_valid_q[READ_LATENCY-1] &  pipe_owner_q[READ_LATENCY-1];

    // Read data is a plain pass-through; consumers qualify it with their rvalid.
    assign bus.p_rdata  = rst ? 32'd0 : bus.mem_dout;
    assign bus.x_rdata  = rst ? 32'd0 : bus.mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard testbench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int RL = 3;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.READ_LATENCY(RL), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        gnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
    } cmd_t;

    typedef struct {
        int          due;
        logic        own_x;
        logic [31:0] data;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];

    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] phys_mem  [logic [31:0]];
    logic [31:0] dly [RL];

    function automatic logic [31:0] init_val(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] phys_read(logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Behavioural memory: fixed latency RL from address cycle to mem_dout.
    always @(posedge clk) begin
        logic [31:0] rv;
        rv = phys_read(bus.mem_addr);
        if (bus.mem_we === 1'b1) phys_mem[bus.mem_addr] = bus.mem_din;
        for (int i = RL - 1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= rv;
    end
    assign bus.mem_dout = dly[RL-1];

    // Reference model state
    int          denied = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_din  = 32'd0;
    logic        m_p_stalled = 1'b0;
    logic        m_x_waiting = 1'b0;

    task automatic drive(input logic r,
                         input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                         input logic xr, input logic xw, input logic [31:0] xa, input logic [31:0] xd);
        cmd_t c;
        logic x_wins, pg, xg;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
        bus.x_req = xr; bus.x_we = xw; bus.x_addr = xa; bus.x_wdata = xd;
        c.rst = r;
        if (r) begin
            c.stall = 0; c.gnt = 0; c.we = 0; c.addr = 0; c.din = 0;
            denied = 0; last_addr = 0; last_din = 0;
            rd_q.delete();
            m_p_stalled = 0; m_x_waiting = 0;
        end else begin
            x_wins = xr && (!pr || denied == MW);
            pg = pr && !x_wins;
            xg = xr && !pg;
            c.stall = pr && !pg;
            c.gnt   = xg;
            c.we = 0; c.addr = last_addr; c.din = last_din;
            if (pg) begin
                c.we = pw; c.addr = pa; c.din = pd;
            end else if (xg) begin
                c.we = xw; c.addr = xa; c.din = xd;
            end
            last_addr = c.addr;
            last_din  = c.din;
            if (pg || xg) begin
                if (c.we) model_mem[c.addr] = c.din;
                else rd_q.push_back('{due: cyc + RL, own_x: xg, data: model_read(c.addr)});
            end
            denied = (xr && !xg) ? ((denied < MW) ? denied + 1 : MW) : 0;
            m_p_stalled = c.stall;
            m_x_waiting = xr && !xg;
        end
        cmd_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented output against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                cmd_t c;
                logic ep, ex;
                logic [31:0] ed;
                if (cmd_q.size() == 0) begin
                    check("cmd_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    c = cmd_q.pop_front();
                    check("p_stall",  32'(bus.p_stall), 32'(c.stall));
                    check("x_gnt",    32'(bus.x_gnt),   32'(c.gnt));
                    check("mem_we",   32'(bus.mem_we),  32'(c.we));
                    check("mem_addr", bus.mem_addr,     c.addr);
                    check("mem_din",  bus.mem_din,      c.din);
                    ep = 0; ex = 0; ed = 0;
                    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                        rd_t e;
                        e  = rd_q.pop_front();
                        ep = !e.own_x;
                        ex = e.own_x;
                        ed = e.data;
                    end
                    check("p_rvalid", 32'(bus.p_rvalid), 32'(ep));
                    check("x_rvalid", 32'(bus.x_rvalid), 32'(ex));
                    if (ep) check("p_rdata", bus.p_rdata, ed);
                    if (ex) check("x_rdata", bus.x_rdata, ed);
                    if (c.rst) begin
                        check("p_rdata_rst", bus.p_rdata, 32'd0);
                        check("x_rdata_rst", bus.x_rdata, 32'd0);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic        pr, pw, xr, xw, r;
        logic [31:0] pa, pd, xa, xd;
        rst = 1;
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
        bus.x_req = 0; bus.x_we = 0; bus.x_addr = 0; bus.x_wdata = 0;
        for (int i = 0; i < RL; i++) dly[i] = 32'd0;
        phys_mem[32'h100]  = 32'hDEAD_BEEF;
        model_mem[32'h100] = 32'hDEAD_BEEF;

        // Reset held with both requesting, then first free cycle goes to P
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
        drive(0, 1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
        idle(RL + 1);

        // P load alone
        drive(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        idle(RL + 1);

        // Both requesting continuously: forced X slot every MW+1 cycles
        pa = 32'h10;
        for (int i = 0; i < 15; i++) begin
            if (!m_p_stalled) pa = 32'($urandom_range(0, 15)) << 2;
            drive(0, 1, 0, pa, 0, 1, 0, 32'h80 + 32'(i), 0);
        end
        idle(RL + 1);

        // X store while P idle
        drive(0, 0, 0, 0, 0, 1, 1, 32'h200, 32'h55);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h200, 0);
        idle(RL + 1);

        // Alternating owners back to back
        drive(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h200, 0);
        drive(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
        idle(RL + 1);

        // Reset right after a P read issues: read is dropped
        drive(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(RL + 2);

        // Randomized traffic; stalled/waiting requesters hold their inputs
        pr = 0; pw = 0; pa = 0; pd = 0; xr = 0; xw = 0; xa = 0; xd = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) == 0);
            if (!m_p_stalled || r) begin
                pr = ($urandom_range(0, 9) < 6);
                pw = $urandom_range(0, 2) == 0;
                pa = 32'($urandom_range(0, 15)) << 2;
                pd = $urandom;
            end
            if (!m_x_waiting || r) begin
                xr = ($urandom_range(0, 9) < 4);
                xw = $urandom_range(0, 2) == 0;
                xa = 32'($urandom_range(0, 15)) << 2;
                xd = $urandom;
            end
            drive(r, pr, pw, pa, pd, xr, xw, xa, xd);
        end
        idle(RL + 2);

        @(negedge clk);
        #1;
        check("reads_drained", 32'(rd_q.size()), 32'd0);
        check("cmds_drained",  32'(cmd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
